// File: rtl/bridge_initiator.sv
// Host-side initiator for the bridge operand interface: takes commands over a valid/ready
// port, drives OPT/RGA/RGB, samples RGZ after a fixed settle time and returns it.
module bridge_initiator #(
  parameter int         WIDTH    = 8,
  parameter int         OPW      = 8,
  parameter int         WAIT_CYC = 2,
  parameter logic [1:0] UNLOCK   = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [1:0]       key,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [OPW-1:0]   req_opt,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [OPW-1:0]   opt,
  output logic [WIDTH-1:0] rga,
  output logic [WIDTH-1:0] rgb,
  input  logic [WIDTH-1:0] rgz,
  output logic             rsp_vld,
  input  logic             rsp_rdy,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_err,
  output logic [7:0]       txn_cnt,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // req_rdy depends only on registered state and ena; rsp_vld/rsp_z/rsp_err are held
  // stable from assertion until the edge that completes the transfer.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       prot_op;
  logic       accept;
  logic       accept_ok;
  logic       accept_err;
  logic       wait_done;
  logic       rsp_done;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept_ok) state_nx = S_WAIT;
              else if (accept_err) state_nx = S_RESP;
      S_WAIT: if (wait_done) state_nx = S_RESP;
      S_RESP: if (rsp_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req_rdy    = (state == S_IDLE) && ena;
    accept     = req_rdy && req_vld;
    prot_op    = req_opt[OPW-1];
    accept_ok  = accept && (!prot_op || (key == UNLOCK));
    accept_err = accept && prot_op && (key != UNLOCK);
    wait_done  = (state == S_WAIT) && (cnt == 4'd1);
    rsp_done   = (state == S_RESP) && rsp_vld && rsp_rdy;
    state_dbg  = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opt     <= '0;
      rga     <= '0;
      rgb     <= '0;
      cnt     <= '0;
      rsp_vld <= 1'b0;
      rsp_z   <= '0;
      rsp_err <= 1'b0;
      txn_cnt <= '0;
    end else begin
      if (accept_ok) begin
        opt <= req_opt;
        rga <= req_a;
        rgb <= req_b;
        cnt <= WAIT_INIT;
      end
      // Rejected protected opcodes never touch the bridge bus.
      if (accept_err) begin
        rsp_z   <= '0;
        rsp_err <= 1'b1;
        rsp_vld <= 1'b1;
      end
      if (state == S_WAIT) begin
        if (wait_done) begin
          rsp_z   <= rgz;
          rsp_err <= 1'b0;
          rsp_vld <= 1'b1;
          cnt     <= '0;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
      if (rsp_done) begin
        rsp_vld <= 1'b0;
        rsp_err <= 1'b0;
        opt     <= '0;
        txn_cnt <= txn_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bridge_initiator.sv
// Directed bench for bridge_initiator: bridge stub RGZ = RGA + RGB, scoreboard of
// expected {err, z} responses popped by a monitor on every response handshake.
module tb_bridge_initiator;

  localparam int WIDTH = 8;
  localparam int OPW   = 8;

  logic             clk;
  logic             rst;
  logic             ena;
  logic [1:0]       key;
  logic             req_vld;
  logic             req_rdy;
  logic [OPW-1:0]   req_opt;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [OPW-1:0]   opt;
  logic [WIDTH-1:0] rga;
  logic [WIDTH-1:0] rgb;
  logic [WIDTH-1:0] rgz;
  logic             rsp_vld;
  logic             rsp_rdy;
  logic [WIDTH-1:0] rsp_z;
  logic             rsp_err;
  logic [7:0]       txn_cnt;
  logic [1:0]       state_dbg;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [WIDTH:0] exp_q[$];

  bridge_initiator #(.WIDTH(WIDTH), .OPW(OPW), .WAIT_CYC(2), .UNLOCK(2'b01)) dut (
    .clk(clk), .rst(rst), .ena(ena), .key(key),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_opt(req_opt), .req_a(req_a), .req_b(req_b),
    .opt(opt), .rga(rga), .rgb(rgb), .rgz(rgz),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_z(rsp_z), .rsp_err(rsp_err),
    .txn_cnt(txn_cnt), .state_dbg(state_dbg)
  );

  // Bridge stub
  assign rgz = rga + rgb;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: compares whenever a response handshake is about to occur.
  always @(negedge clk) begin
    if (!rst && rsp_vld && rsp_rdy) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_rsp", {23'd0, rsp_err, rsp_z}, 32'hFFFF_FFFF);
      end else begin
        logic [WIDTH:0] e;
        e = exp_q.pop_front();
        check("sb_rsp", {23'd0, rsp_err, rsp_z}, {23'd0, e});
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns just after the accepting edge.
  task automatic issue(input logic [7:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] k, input logic e_err, input logic [7:0] e_z);
    int n = 0;
    while (!req_rdy && n < 50) begin
      tick();
      n++;
    end
    if (!req_rdy) check("req_rdy_timeout", {31'd0, req_rdy}, 32'd1);
    req_vld = 1'b1;
    req_opt = o;
    req_a   = a;
    req_b   = b;
    key     = k;
    exp_q.push_back({e_err, e_z});
    tick();
    req_vld = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_vld && n < 50) begin
      tick();
      n++;
    end
    if (!rsp_vld) begin
      check("rsp_timeout", {31'd0, rsp_vld}, 32'd1);
    end else begin
      rsp_rdy = 1'b1;
      tick();
      rsp_rdy = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; key = 2'b00; req_vld = 1'b0;
    req_opt = '0; req_a = '0; req_b = '0; rsp_rdy = 1'b0;

    // 1 Reset
    tick(); tick();
    check("rst_opt", {24'd0, opt}, 32'd0);
    check("rst_rga", {24'd0, rga}, 32'd0);
    check("rst_rgb", {24'd0, rgb}, 32'd0);
    check("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    check("rst_rsp_z", {24'd0, rsp_z}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_txn_cnt", {24'd0, txn_cnt}, 32'd0);
    rst = 1'b0;
    tick();
    check("rst_req_rdy", {31'd0, req_rdy}, 32'd1);

    // 2 Normal operation
    issue(8'h01, 8'h07, 8'h01, 2'b00, 1'b0, 8'h08);
    check("norm_opt", {24'd0, opt}, 32'h01);
    check("norm_rga", {24'd0, rga}, 32'h07);
    check("norm_rgb", {24'd0, rgb}, 32'h01);
    check("norm_vld_k", {31'd0, rsp_vld}, 32'd0);
    check("norm_req_rdy_busy", {31'd0, req_rdy}, 32'd0);
    tick();
    check("norm_vld_k1", {31'd0, rsp_vld}, 32'd0);
    tick();
    check("norm_vld_k2", {31'd0, rsp_vld}, 32'd1);
    check("norm_z", {24'd0, rsp_z}, 32'h08);
    check("norm_err", {31'd0, rsp_err}, 32'd0);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    check("norm_opt_nop", {24'd0, opt}, 32'h00);
    check("norm_txn", {24'd0, txn_cnt}, 32'd1);
    check("norm_vld_clr", {31'd0, rsp_vld}, 32'd0);
    check("norm_rga_hold", {24'd0, rga}, 32'h07);

    // 3 Protection: locked then unlocked
    issue(8'h81, 8'h05, 8'h03, 2'b11, 1'b1, 8'h00);
    check("prot_vld", {31'd0, rsp_vld}, 32'd1);
    check("prot_err", {31'd0, rsp_err}, 32'd1);
    check("prot_z", {24'd0, rsp_z}, 32'h00);
    check("prot_opt", {24'd0, opt}, 32'h00);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    check("prot_txn", {24'd0, txn_cnt}, 32'd2);
    issue(8'h81, 8'h05, 8'h03, 2'b01, 1'b0, 8'h08);
    key = 2'b11;
    check("unlk_opt", {24'd0, opt}, 32'h81);
    tick(); tick();
    check("unlk_vld", {31'd0, rsp_vld}, 32'd1);
    check("unlk_err", {31'd0, rsp_err}, 32'd0);
    check("unlk_z", {24'd0, rsp_z}, 32'h08);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;

    // 4 Backpressure
    issue(8'h02, 8'h10, 8'h20, 2'b00, 1'b0, 8'h30);
    wait_rsp_hold: begin
      int n = 0;
      while (!rsp_vld && n < 50) begin tick(); n++; end
    end
    req_vld = 1'b1; req_opt = 8'h03; req_a = 8'h01; req_b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_vld", {31'd0, rsp_vld}, 32'd1);
      check("bp_z", {24'd0, rsp_z}, 32'h30);
      check("bp_req_rdy", {31'd0, req_rdy}, 32'd0);
      check("bp_opt", {24'd0, opt}, 32'h02);
    end
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    check("bp_release_vld", {31'd0, rsp_vld}, 32'd0);
    check("bp_release_rdy", {31'd0, req_rdy}, 32'd1);
    exp_q.push_back({1'b0, 8'h02});
    tick();
    req_vld = 1'b0;
    check("bp_next_opt", {24'd0, opt}, 32'h03);
    check("bp_next_rga", {24'd0, rga}, 32'h01);
    wait_rsp();
    check("bp_txn", {24'd0, txn_cnt}, 32'd5);

    // 5 Reset mid-operation
    issue(8'h04, 8'h01, 8'h02, 2'b00, 1'b0, 8'h03);
    exp_q.delete();
    check("mid_state_wait", {30'd0, state_dbg}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_opt", {24'd0, opt}, 32'd0);
    check("mid_rga", {24'd0, rga}, 32'd0);
    check("mid_rgb", {24'd0, rgb}, 32'd0);
    check("mid_vld", {31'd0, rsp_vld}, 32'd0);
    check("mid_txn", {24'd0, txn_cnt}, 32'd0);
    check("mid_state", {30'd0, state_dbg}, 32'd0);
    tick(); tick(); tick();
    check("mid_no_rsp", {31'd0, rsp_vld}, 32'd0);

    // 6 ENA gating and counter wrap
    ena = 1'b0;
    req_vld = 1'b1; req_opt = 8'h05; req_a = 8'h09; req_b = 8'h09;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ena_req_rdy", {31'd0, req_rdy}, 32'd0);
      check("ena_opt", {24'd0, opt}, 32'd0);
    end
    req_vld = 1'b0;
    ena = 1'b1;
    tick();
    check("ena_req_rdy_on", {31'd0, req_rdy}, 32'd1);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a, b;
      a = 8'(i);
      b = 8'h5A ^ 8'(i);
      issue({1'b0, a[6:0]}, a, b, 2'b10, 1'b0, a + b);
      wait_rsp();
      if (i == 254) check("wrap_txn_255", {24'd0, txn_cnt}, 32'd255);
    end
    check("wrap_txn_0", {24'd0, txn_cnt}, 32'd0);

    tick(); tick();
    check("sb_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
